// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants for the Sobel front-end window sequencer.
package sobel_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 5;
  localparam int ADDR_W_DEF = 16;
  localparam int PIX_W      = 8;
endpackage

// File: rtl/sobel_ctrl_delay.sv
// sobel_ctrl_delay: fixed-depth shift register that ages control strobes alongside the pixel path.
module sobel_ctrl_delay #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: frame sequencer issuing three-row read addresses and tagging in-row 3x3 windows.
// Optional per-frame window counter output enabled by SOBEL_WINDOW_CTRL_PERF_EN.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MOD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stall_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr0_o,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [ADDR_W-1:0] addr2_o,
  output logic              mod_done_o,
  output logic              win_valid_o,
  output logic              busy_o,
  output logic              done_o
`ifdef SOBEL_WINDOW_CTRL_PERF_EN
  ,
  output logic [15:0]       win_cnt_o
`endif
);
  localparam int NRD = (IMG_H - 2) * IMG_W;
  localparam int CW  = $clog2(IMG_W);
  localparam int FW  = $clog2(MOD_LAT + 2);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
  logic [CW-1:0]     col_q, col_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              go, issue, last, adv;
  logic [1:0]        tag_dly;
  assign go    = state_q == S_IDLE && start_i;
  assign issue = state_q == S_RUN && !stall_i;
  assign last  = a0_q == ADDR_W'(NRD - 1);
  // the final read leaves the addresses parked on their last value
  assign adv   = issue && !last;
  always_comb begin
    state_d = go ? S_RUN
            : (issue && last) ? S_FLUSH
            : (state_q == S_FLUSH && fcnt_q == FW'(MOD_LAT)) ? S_DONE
            : state_q == S_DONE ? S_IDLE : state_q;
    a0_d    = go ? '0 : adv ? a0_q + ADDR_W'(1) : a0_q;
    a1_d    = go ? ADDR_W'(IMG_W) : adv ? a1_q + ADDR_W'(1) : a1_q;
    a2_d    = go ? ADDR_W'(2 * IMG_W) : adv ? a2_q + ADDR_W'(1) : a2_q;
    col_d   = go ? '0 : !issue ? col_q : col_q == CW'(IMG_W - 1) ? '0 : col_q + CW'(1);
    fcnt_d  = state_q == S_FLUSH ? fcnt_q + FW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      col_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      col_q   <= col_d;
      fcnt_q  <= fcnt_d;
    end
  assign rd_en_o = issue;
  assign addr0_o = a0_q;
  assign addr1_o = a1_q;
  assign addr2_o = a2_q;
  assign busy_o  = state_q == S_RUN || state_q == S_FLUSH;
  assign done_o  = state_q == S_DONE;
  sobel_ctrl_delay #(.W(1), .DEPTH(1)) u_mod_done (
    .clk  (clk),
    .rst_n(rst),
    .d_i  (issue),
    .q_o  (mod_done_o)
  );
  // a column whose left two neighbours are in the same row completes a window
  sobel_ctrl_delay #(.W(2), .DEPTH(1 + MOD_LAT)) u_win (
    .clk  (clk),
    .rst_n(rst),
    .d_i  ({issue, col_q >= CW'(2)}),
    .q_o  (tag_dly)
  );
  assign win_valid_o = &tag_dly;
`ifdef SOBEL_WINDOW_CTRL_PERF_EN
  logic [15:0] win_cnt_q, win_cnt_d;
  always_comb
    win_cnt_d = go ? '0 : (win_valid_o && win_cnt_q != 16'hFFFF) ? win_cnt_q + 16'd1 : win_cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) win_cnt_q <= '0;
    else win_cnt_q <= win_cnt_d;
  assign win_cnt_o = win_cnt_q;
`endif
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: randomized frames checked against a read-count based model of the sequencer.
module tb_sobel_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 5;
  localparam int AW = 16;
  localparam int ML = 1;
  localparam int N  = (H - 2) * W;
  localparam int NWIN = (W - 2) * (H - 2);
  logic          clk = 0;
  logic          rst_n = 0;
  logic          start_i = 0;
  logic          stall_i = 0;
  logic          rd_en_o, mod_done_o, win_valid_o, busy_o, done_o;
  logic [AW-1:0] addr0_o, addr1_o, addr2_o;
`ifdef SOBEL_WINDOW_CTRL_PERF_EN
  logic [15:0]   win_cnt_o;
`endif
  int n_chk = 0;
  int n_fail = 0;
  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MOD_LAT(ML)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start_i    (start_i),
    .stall_i    (stall_i),
    .rd_en_o    (rd_en_o),
    .addr0_o    (addr0_o),
    .addr1_o    (addr1_o),
    .addr2_o    (addr2_o),
    .mod_done_o (mod_done_o),
    .win_valid_o(win_valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
`ifdef SOBEL_WINDOW_CTRL_PERF_EN
    ,
    .win_cnt_o  (win_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  // Model: k reads issued so far; the address of a read is simply k, its column k%W.
  // hist[i] holds the address read i+1 cycles ago (-1 when no read).
  task automatic frame(input int stall_pct, input int rst_k, input int stall_at, input bit hold_start);
    int k = 0, since = 0, wins = 0, cyc = 0, st_cnt = 0;
    int hist[$];
    bit issue, done_seen = 0;
    for (int i = 0; i <= ML; i++) hist.push_front(-1);
    start_i = 1;
    @(negedge clk);
    while (!done_seen && cyc < 200) begin
      start_i = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      if (k == stall_at && st_cnt < 3) begin
        stall_i = 1;
        st_cnt++;
      end else stall_i = ($urandom_range(0, 99) < stall_pct);
      #1;
      issue = (k < N) && !stall_i;
`ifdef SOBEL_WINDOW_CTRL_PERF_EN
      if (cyc == 0) check("win_cnt_clr", win_cnt_o, 0);
`endif
      check("rd_en", rd_en_o, issue);
      check("addr0", addr0_o, k < N ? k : N - 1);
      check("addr1", addr1_o, (k < N ? k : N - 1) + W);
      check("addr2", addr2_o, (k < N ? k : N - 1) + 2 * W);
      check("busy", busy_o, (k < N) || since <= ML + 1);
      check("done", done_o, k == N && since == ML + 2);
      check("mod_done", mod_done_o, hist[0] >= 0);
      check("win_valid", win_valid_o, hist[ML] >= 0 && hist[ML] % W >= 2);
      if (rst_k >= 0 && k == rst_k) begin
        #2 rst_n = 0;
        #1;
        check("rst_outs", {rd_en_o, mod_done_o, win_valid_o, busy_o, done_o}, 0);
        check("rst_addr", addr0_o | addr1_o | addr2_o, 0);
        @(negedge clk);
        rst_n = 1;
        stall_i = 0;
        start_i = 0;
        repeat (4) begin
          #1 check("post_rst", {rd_en_o, mod_done_o, win_valid_o, busy_o, done_o}, 0);
          @(negedge clk);
        end
        return;
      end
      if (win_valid_o) wins++;
      if (done_o) begin
        done_seen = 1;
`ifdef SOBEL_WINDOW_CTRL_PERF_EN
        check("win_cnt", win_cnt_o, NWIN);
`endif
      end
      hist.push_front(issue ? k : -1);
      void'(hist.pop_back());
      if (issue) k++;
      if (k == N) since++;
      cyc++;
      @(negedge clk);
    end
    if (!done_seen) check("done_timeout", 0, 1);
    check("win_total", wins, NWIN);
    start_i = hold_start;
    stall_i = 0;
    #1;
    check("idle_outs", {rd_en_o, mod_done_o, win_valid_o, busy_o, done_o}, 0);
    check("idle_addr", addr0_o, N - 1);
  endtask
  initial begin
    #2;
    check("reset_outs", {rd_en_o, mod_done_o, win_valid_o, busy_o, done_o}, 0);
    check("reset_addr", addr0_o | addr1_o | addr2_o, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    frame(0, -1, -1, 0);
    frame(0, -1, 10, 0);
    frame(20, -1, -1, 1);
    frame(30, -1, -1, 0);
    frame(0, 12, -1, 0);
    frame(0, -1, -1, 0);
    repeat (4) frame($urandom_range(0, 60), -1, -1, 1'($urandom_range(0, 1)));
    frame(0, -1, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Frame-level sequencer for the Sobel front end. Walks a stored IMG_W x IMG_H 8-bit frame and issues three row-aligned read addresses per cycle to the line/frame memory.
- Drives done_i of sobel_data_modulate, which consumes the three returned pixels as one column.
- Produces a window-valid strobe aligned with the modulator's 3x3 output, so downstream gradient logic ignores windows that straddle a row boundary.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 5, image height in pixels (>=3)
- ADDR_W, 16, memory address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
- MOD_LAT, 1, sobel_data_modulate input-to-output latency in cycles

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  frame start request, sampled in IDLE only
- stall_i  in  1  downstream back-pressure; high = hold sequencing
- rd_en_o  out  1  memory read enable (synchronous RAM, 1-cycle read latency)
- addr0_o  out  ADDR_W  top-row pixel address
- addr1_o  out  ADDR_W  middle-row address = addr0_o + IMG_W
- addr2_o  out  ADDR_W  bottom-row address = addr0_o + 2*IMG_W
- mod_done_o  out  1  to sobel_data_modulate done_i; rd_en_o delayed 1 cycle
- win_valid_o  out  1  modulator d0_o..d8_o hold a complete in-row 3x3 window
- busy_o  out  1  high in RUN and FLUSH
- done_o  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all counters 0; every output 0.
- FSM: IDLE -> RUN on start_i=1. RUN -> FLUSH after the last read is issued. FLUSH -> DONE after MOD_LAT+1 cycles. DONE -> IDLE unconditionally after 1 cycle.
- RUN reads:
  - rd_en_o=1 in every RUN cycle with stall_i=0.
  - addr0_o runs linearly 0 .. (IMG_H-2)*IMG_W-1, incremented by 1 per issued read. No multiplier is used; row wrap is implicit in the linear address.
  - A column counter col (0..IMG_W-1) runs alongside and wraps to 0 after IMG_W-1.
- Read count: total reads per frame = (IMG_H-2)*IMG_W. Valid windows per frame = (IMG_W-2)*(IMG_H-2).
- Stall:
  - When stall_i=1 in RUN: rd_en_o=0; addr0_o, addr1_o, addr2_o and col hold.
  - The following cycle, mod_done_o=0.
  - stall_i has no effect in IDLE, FLUSH or DONE.
- Window tagging:
  - Each issued read carries the tag (col>=2).
  - The tag is delayed by 1+MOD_LAT cycles together with the read enable.
  - win_valid_o = delayed enable AND delayed tag.
  - Result: the first two columns of each row never assert win_valid_o.
- Address outputs:
  - Registered; all three are updated in the same cycle.
  - Arithmetic is unsigned ADDR_W-bit.
  - addr outputs hold their last value in FLUSH and DONE.
  - They return to 0 on the next IDLE->RUN transition.
- Status outputs:
  - busy_o=1 throughout RUN and FLUSH.
  - done_o=1 only in DONE.
  - start_i is ignored while busy_o=1 or done_o=1.
  - start_i held high in IDLE begins a new frame the cycle after DONE.
- Reset mid-frame: immediate return to IDLE. The delay pipeline is cleared, so no stray mod_done_o or win_valid_o is produced, and done_o is not issued.

Optional Feature:
- Macro: SOBEL_WINDOW_CTRL_PERF_EN
- Defined:
  - Adds output win_cnt_o [15:0], which counts win_valid_o pulses in the current frame.
  - Cleared on the IDLE->RUN transition; saturates at 16'hFFFF.
  - Holds its value after done_o until the next start.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sobel_pkg:
  - State encoding localparams (IDLE=0, RUN=1, FLUSH=2, DONE=3).
  - Default IMG_W, IMG_H and ADDR_W constants.
  - Pixel width constant (8).
- Sub-module sobel_ctrl_delay:
  - Parameterised-depth shift register (DEPTH=1+MOD_LAT) carrying {enable, tag}.
  - Asynchronous active-low reset.
  - Also reused to generate mod_done_o (DEPTH=1).

Test Plan:
- Basic frame: IMG_W=8, IMG_H=5; start_i pulse, stall_i=0 -> rd_en_o high for 24 consecutive cycles; addr0_o sweeps 0..23 with addr1_o=addr0_o+8 and addr2_o=addr0_o+16; exactly 18 win_valid_o pulses; done_o one cycle, MOD_LAT+2 cycles after the last read.
- Row boundary: same frame -> win_valid_o low for the outputs from addresses 0,1,8,9,16,17 and high for all other addresses.
- Stall: stall_i=1 for 3 cycles when addr0_o=10 -> addr0_o holds at 10; rd_en_o=0 for 3 cycles; mod_done_o gap of 3 cycles one cycle later; window total still 18.
- Restart: start_i held high -> second frame begins the cycle after DONE; start_i pulses during RUN ignored; addresses restart at 0.
- Reset mid-frame: rst=0 at addr0_o=12 -> all outputs 0 asynchronously; no done_o; a new start after release gives a full 18-window frame.
- PERF_EN: with the macro defined, run the basic frame -> win_cnt_o=18 after done_o; cleared to 0 on the next start.
